vga_pattern_overlay: RTL and testbench
======================================

// Module: vga_pattern_overlay
// PURPOSE
//   Sits directly downstream of the VGA timing/pattern generator, upstream of the HDMI/VGA transmitter.
//   Recovers pixel x/y position from the incoming hs/vs/de stream and replaces or passes the incoming RGB.
//   Output choices: colour bars, border, grid or an animated ramp.
//   Delays sync/de by the same pipeline depth so timing at the transmitter stays aligned with RGB.
// PARAMETERS
//   H_ACTIVE   1920  active pixels per line (border right edge, bar width = H_ACTIVE/8)
//   V_ACTIVE   1080  active lines per frame (border bottom edge)
//   GRID_SHIFT 5     grid pitch = 2**GRID_SHIFT pixels/lines
// PORTS
//   clk        in   1   pixel clock, all logic on rising edge
//   reset      in   1   synchronous, active-high reset
//   in_hs      in   1   horizontal sync, active-low
//   in_vs      in   1   vertical sync, active-low
//   in_de      in   1   data enable, high on active pixels
//   in_r/g/b   in   8   incoming pixel colour (each)
//   mode       in   3   pattern select, sampled only at frame start
//   out_hs     out  1   in_hs delayed 2 clocks
//   out_vs     out  1   in_vs delayed 2 clocks
//   out_de     out  1   in_de delayed 2 clocks
//   out_r/g/b  out  8   output pixel colour (each), aligned with out_de
//   frame_cnt  out  8   frames seen since reset, wraps 255->0
// BEHAVIOUR
//   Reset:
//   - out_hs = 1, out_vs = 1, out_de = 0, out_r/g/b = 0, frame_cnt = 0.
//   - Internal x = 0, y = 0, active_mode = 0, bar index = 0, and both pipeline stages are cleared to these same values.
//   Frame start: in_vs falling edge (registered previous vs = 1, current = 0).
//   - y <= 0.
//   - frame_cnt <= frame_cnt + 1.
//   - active_mode <= mode.
//   - mode changes at any other time have no effect.
//   x counter (12-bit):
//   - 0 while in_de = 0; +1 per cycle while in_de = 1.
//   - Saturates at 4095, no wrap.
//   y counter (12-bit):
//   - +1 on each in_de falling edge; saturates at 4095.
//   - Frame start has priority over a simultaneous de falling edge.
//   Bar index (3-bit) and bar pixel counter:
//   - Both clear when in_de = 0.
//   - During de, the pixel counter counts 0..H_ACTIVE/8-1; on the last value it clears and the index increments, saturating at 7.
//   - No divider.
//   Stage 1 registers x, y, bar index, the delayed sync/de/RGB and active_mode.
//   Stage 2 computes colour and drives the outputs. Total latency is 2 clocks for every output.
//   Colour by active_mode:
//   - 0: pass-through {in_r, in_g, in_b}.
//   - 1: 8 colour bars by index 0..7 = white, yellow, cyan, green, magenta, red, blue, black (components FF/00).
//   - 2: border. White when x == 0, x == H_ACTIVE-1, y == 0 or y == V_ACTIVE-1; else pass-through.
//   - 3: grid. White when x[GRID_SHIFT-1:0] == 0 or y[GRID_SHIFT-1:0] == 0; else black.
//   - 4: ramp. r = x[7:0] + frame_cnt (mod 256), g = y[7:0], b = 0.
//   - 5-7: pass-through.
//   Blanking: whenever the stage-1 de = 0, out_r/g/b = 0 regardless of mode.
//   Reset asserted mid-frame:
//   - Outputs take reset values on the next clock.
//   - After release, the pattern runs in mode 0 until the next in_vs falling edge latches mode.
//   - frame_cnt restarts at 0 and counts from that falling edge.
//   Back-to-back de pulses with a 1-cycle gap: x restarts at 0 and y increments once.
// TESTING
//   Frame start: mode = 3'd1, 1920x1080 timing, in_vs falling edge -> next frame out_r/g/b at x = 0 are FFFFFF and at x = 240 are FFFF00.
//   Bar alignment: in mode 1, the pixel with out_de high at x = 1919 -> 000000; the first out_de edge occurs exactly 2 clocks after the in_de edge.
//   Border: mode 2, in_r/g/b = 102030 -> y = 5, x = 0 gives FFFFFF; y = 5, x = 7 gives 102030; y = 1079, x = 7 gives FFFFFF.
//   Ramp and wrap: mode 4 after 255 frames -> frame_cnt = 255 and pixel x = 3 gives r = 02. After the next frame start, frame_cnt = 0 and x = 3 gives r = 03.
//   Mode change mid-frame: mode 1 -> 3 changed at line 500 -> bars persist to the end of the frame, grid from the next vs falling edge.
//   Reset at line 300 of mode 3: held 4 clocks -> outputs 1/1/0/000000 with frame_cnt = 0; output is pass-through until the next vs falling edge, then frame_cnt = 1.

Source files
------------

// File: rtl/vga_pattern_overlay.sv
// Pattern overlay for a VGA/HDMI pixel stream: recovers x/y from hs/vs/de and
// replaces or passes RGB through a 2-stage pipeline with matching sync delay.
module vga_pattern_overlay #(
    parameter int H_ACTIVE   = 1920,
    parameter int V_ACTIVE   = 1080,
    parameter int GRID_SHIFT = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_hs,
    input  logic       in_vs,
    input  logic       in_de,
    input  logic [7:0] in_r,
    input  logic [7:0] in_g,
    input  logic [7:0] in_b,
    input  logic [2:0] mode,
    output logic       out_hs,
    output logic       out_vs,
    output logic       out_de,
    output logic [7:0] out_r,
    output logic [7:0] out_g,
    output logic [7:0] out_b,
    output logic [7:0] frame_cnt
);

    localparam logic [11:0] BAR_LAST = 12'(H_ACTIVE / 8 - 1);
    localparam logic [11:0] X_LAST   = 12'(H_ACTIVE - 1);
    localparam logic [11:0] Y_LAST   = 12'(V_ACTIVE - 1);
    localparam logic [11:0] CNT_MAX  = 12'hFFF;

    // position tracking, all referring to the pixel currently on the inputs
    logic        r_prev_vs;
    logic        r_prev_de;
    logic [11:0] r_x;
    logic [11:0] r_y;
    logic [11:0] r_bar_pix;
    logic [2:0]  r_bar_idx;
    logic [2:0]  r_mode;
    logic [7:0]  r_frame_cnt;

    // stage 1
    logic        r_s1_hs;
    logic        r_s1_vs;
    logic        r_s1_de;
    logic [7:0]  r_s1_r;
    logic [7:0]  r_s1_g;
    logic [7:0]  r_s1_b;
    logic [11:0] r_s1_x;
    logic [11:0] r_s1_y;
    logic [2:0]  r_s1_bar;
    logic [2:0]  r_s1_mode;

    // stage 2
    logic        r_out_hs;
    logic        r_out_vs;
    logic        r_out_de;
    logic [23:0] r_out_rgb;

    logic        w_frame_start;
    logic        w_de_fall;
    logic [23:0] w_px;
    logic        w_border;
    logic        w_grid;
    logic [7:0]  w_ramp_r;
    logic [23:0] w_colour;
    logic [23:0] w_bar_rgb [8];

    assign w_frame_start = r_prev_vs & ~in_vs;
    assign w_de_fall     = r_prev_de & ~in_de;

    // Bar order white..black falls out of the inverted index bits: r=~i[1], g=~i[2], b=~i[0]
    for (genvar gi = 0; gi < 8; gi++) begin : g_bar
        localparam logic [2:0] IDX = 3'(gi);
        assign w_bar_rgb[gi] = {{8{~IDX[1]}}, {8{~IDX[2]}}, {8{~IDX[0]}}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_vs   <= 1'b1;
            r_prev_de   <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_bar_pix   <= '0;
            r_bar_idx   <= '0;
            r_mode      <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_prev_vs <= in_vs;
            r_prev_de <= in_de;

            if (!in_de) begin
                r_x <= '0;
            end else if (r_x != CNT_MAX) begin
                r_x <= r_x + 12'd1;
            end

            // frame start wins over a coincident end-of-line
            if (w_frame_start) begin
                r_y         <= '0;
                r_frame_cnt <= r_frame_cnt + 8'd1;
                r_mode      <= mode;
            end else if (w_de_fall && r_y != CNT_MAX) begin
                r_y <= r_y + 12'd1;
            end

            if (!in_de) begin
                r_bar_pix <= '0;
                r_bar_idx <= '0;
            end else if (r_bar_pix == BAR_LAST) begin
                r_bar_pix <= '0;
                if (r_bar_idx != 3'd7) begin
                    r_bar_idx <= r_bar_idx + 3'd1;
                end
            end else begin
                r_bar_pix <= r_bar_pix + 12'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_hs   <= 1'b1;
            r_s1_vs   <= 1'b1;
            r_s1_de   <= 1'b0;
            r_s1_r    <= '0;
            r_s1_g    <= '0;
            r_s1_b    <= '0;
            r_s1_x    <= '0;
            r_s1_y    <= '0;
            r_s1_bar  <= '0;
            r_s1_mode <= '0;
        end else begin
            r_s1_hs   <= in_hs;
            r_s1_vs   <= in_vs;
            r_s1_de   <= in_de;
            r_s1_r    <= in_r;
            r_s1_g    <= in_g;
            r_s1_b    <= in_b;
            r_s1_x    <= r_x;
            r_s1_y    <= r_y;
            r_s1_bar  <= r_bar_idx;
            r_s1_mode <= r_mode;
        end
    end

    always_comb begin
        w_px     = {r_s1_r, r_s1_g, r_s1_b};
        w_border = (r_s1_x == '0) || (r_s1_x == X_LAST) ||
                   (r_s1_y == '0) || (r_s1_y == Y_LAST);
        w_grid   = (r_s1_x[GRID_SHIFT-1:0] == '0) || (r_s1_y[GRID_SHIFT-1:0] == '0);
        w_ramp_r = r_s1_x[7:0] + r_frame_cnt;
        w_colour = w_px;
        case (r_s1_mode)
            3'd1:    w_colour = w_bar_rgb[r_s1_bar];
            3'd2:    w_colour = w_border ? 24'hFFFFFF : w_px;
            3'd3:    w_colour = w_grid ? 24'hFFFFFF : 24'h000000;
            3'd4:    w_colour = {w_ramp_r, r_s1_y[7:0], 8'h00};
            default: w_colour = w_px;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_hs  <= 1'b1;
            r_out_vs  <= 1'b1;
            r_out_de  <= 1'b0;
            r_out_rgb <= '0;
        end else begin
            r_out_hs  <= r_s1_hs;
            r_out_vs  <= r_s1_vs;
            r_out_de  <= r_s1_de;
            r_out_rgb <= r_s1_de ? w_colour : 24'h000000;
        end
    end

    assign out_hs    = r_out_hs;
    assign out_vs    = r_out_vs;
    assign out_de    = r_out_de;
    assign out_r     = r_out_rgb[23:16];
    assign out_g     = r_out_rgb[15:8];
    assign out_b     = r_out_rgb[7:0];
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_vga_pattern_overlay.sv
// Scoreboard bench for vga_pattern_overlay: random frames, expected outputs
// from a spec-level model, compared by a separate monitor two clocks later.
module tb_vga_pattern_overlay;

    localparam int H  = 64;
    localparam int V  = 10;
    localparam int GS = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_hs, in_vs, in_de;
    logic [7:0] in_r, in_g, in_b;
    logic [2:0] mode;
    logic       out_hs, out_vs, out_de;
    logic [7:0] out_r, out_g, out_b;
    logic [7:0] frame_cnt;

    always #5 clk = ~clk;

    vga_pattern_overlay #(.H_ACTIVE(H), .V_ACTIVE(V), .GRID_SHIFT(GS)) dut (
        .clk(clk), .reset(reset),
        .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de),
        .in_r(in_r), .in_g(in_g), .in_b(in_b), .mode(mode),
        .out_hs(out_hs), .out_vs(out_vs), .out_de(out_de),
        .out_r(out_r), .out_g(out_g), .out_b(out_b),
        .frame_cnt(frame_cnt)
    );

    typedef struct packed {
        logic [31:0] due;
        logic        hs;
        logic        vs;
        logic        de;
        logic [23:0] rgb;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic [23:0] bar_tab [0:7] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                   24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    // reference model state, as seen at the input side
    bit         m_prev_vs = 1'b1;
    bit         m_prev_de = 1'b0;
    int         m_run = 0;
    int         m_y = 0;
    logic [2:0] m_mode = 3'd0;
    logic [7:0] m_fcnt = 8'd0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] ref_colour(input int x, input int y, input logic [2:0] md,
                                               input logic [23:0] px, input logic [7:0] fc);
        int         idx;
        logic [7:0] rr;
        case (md)
            3'd1: begin
                idx = x / (H / 8);
                if (idx > 7) idx = 7;
                return bar_tab[idx];
            end
            3'd2: return (x == 0 || x == H - 1 || y == 0 || y == V - 1) ? 24'hFFFFFF : px;
            3'd3: return ((x % (1 << GS)) == 0 || (y % (1 << GS)) == 0) ? 24'hFFFFFF : 24'h000000;
            3'd4: begin
                rr = 8'(x) + fc;
                return {rr, 8'(y), 8'h00};
            end
            default: return px;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // one input cycle: drive, then advance the model and queue the expected output
    task automatic drive(input logic hs, input logic vs, input logic de,
                         input logic [23:0] px, input logic [2:0] md);
        exp_t e;
        int   x;
        bit   fs;
        @(negedge clk);
        in_hs = hs; in_vs = vs; in_de = de;
        {in_r, in_g, in_b} = px;
        mode = md;
        fs = m_prev_vs && !vs;
        x  = (m_run > 4095) ? 4095 : m_run;
        if (fs) m_fcnt = m_fcnt + 8'd1;
        e.due = 32'(cyc + 2);
        e.hs  = hs;
        e.vs  = vs;
        e.de  = de;
        e.rgb = de ? ref_colour(x, m_y, m_mode, px, m_fcnt) : 24'h000000;
        q.push_back(e);
        if (de) m_run++; else m_run = 0;
        if (fs) begin
            m_y    = 0;
            m_mode = md;
        end else if (m_prev_de && !de) begin
            m_y = (m_y < 4095) ? m_y + 1 : 4095;
        end
        m_prev_vs = vs;
        m_prev_de = de;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_hs = 1'b1; in_vs = 1'b1; in_de = 1'b0;
        q.delete();
        repeat (4) @(negedge clk);
        chk("rst_hs", 32'(out_hs), 32'd1);
        chk("rst_vs", 32'(out_vs), 32'd1);
        chk("rst_de", 32'(out_de), 32'd0);
        chk("rst_rgb", 32'({out_r, out_g, out_b}), 32'd0);
        chk("rst_fcnt", 32'(frame_cnt), 32'd0);
        reset = 1'b0;
        m_prev_vs = 1'b1; m_prev_de = 1'b0;
        m_run = 0; m_y = 0; m_mode = 3'd0; m_fcnt = 8'd0;
        $display("reset: outputs checked, model cleared");
    endtask

    task automatic frame(input logic [2:0] fmode, input int lines, input int long_line,
                         input int rst_line, input bit use_fixed, input logic [23:0] fixed_rgb);
        int          w, gap;
        logic [23:0] px;
        repeat (2) drive(1'b1, 1'b0, 1'b0, 24'($urandom), fmode);
        repeat (3) drive(1'b1, 1'b1, 1'b0, 24'($urandom), 3'($urandom));
        for (int l = 0; l < lines; l++) begin
            if (l == rst_line) do_reset();
            w = (l == long_line) ? 4100 : H;
            for (int c = 0; c < w; c++) begin
                px = use_fixed ? fixed_rgb : 24'($urandom);
                drive(1'b1, 1'b1, 1'b1, px, 3'($urandom));
            end
            gap = $urandom_range(1, 5);
            for (int g = 0; g < gap; g++)
                drive((g == 0 && gap > 1) ? 1'b0 : 1'b1, 1'b1, 1'b0, 24'($urandom), 3'($urandom));
        end
        @(negedge clk);
        chk("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
        $display("frame: mode=%0d lines=%0d frame_cnt=%0d checks=%0d", fmode, lines, frame_cnt, checks);
    endtask

    // monitor: compare every queued expectation on the clock it falls due
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (q.size() > 0 && q[0].due <= 32'(cyc)) begin
                e = q.pop_front();
                if (e.due == 32'(cyc)) begin
                    checks++;
                    if ({out_hs, out_vs, out_de, out_r, out_g, out_b} !== {e.hs, e.vs, e.de, e.rgb}) begin
                        errors++;
                        $display("FAIL pix cyc=%0d got hs=%b vs=%b de=%b rgb=%06h exp hs=%b vs=%b de=%b rgb=%06h",
                                 cyc, out_hs, out_vs, out_de, {out_r, out_g, out_b},
                                 e.hs, e.vs, e.de, e.rgb);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        in_hs = 1'b1; in_vs = 1'b1; in_de = 1'b0;
        {in_r, in_g, in_b} = 24'h0;
        mode = 3'd0;
        do_reset();
        frame(3'd1, V, -1, -1, 1'b0, 24'h0);
        frame(3'd2, V, -1, -1, 1'b1, 24'h102030);
        frame(3'd3, V, -1, -1, 1'b0, 24'h0);
        frame(3'd4, V, -1, -1, 1'b0, 24'h0);
        frame(3'd0, V, -1, -1, 1'b0, 24'h0);
        frame(3'd3, V, -1, 3, 1'b0, 24'h0);
        frame(3'd1, V, -1, -1, 1'b0, 24'h0);
        frame(3'd6, V, -1, -1, 1'b0, 24'h0);
        frame(3'd4, V, 1, -1, 1'b0, 24'h0);
        frame(3'd2, V, 2, -1, 1'b0, 24'h0);
        for (int i = 0; i < 5; i++)
            frame(3'($urandom), V + $urandom_range(0, 2), -1, -1, 1'b0, 24'h0);
        // empty frames to bring frame_cnt up to the wrap point
        while (m_fcnt != 8'd254) begin
            drive(1'b1, 1'b0, 1'b0, 24'($urandom), 3'd4);
            repeat (2) drive(1'b1, 1'b1, 1'b0, 24'($urandom), 3'($urandom));
        end
        frame(3'd4, 3, -1, -1, 1'b0, 24'h0);
        frame(3'd4, 3, -1, -1, 1'b0, 24'h0);
        repeat (4) drive(1'b1, 1'b1, 1'b0, 24'($urandom), 3'($urandom));
        repeat (4) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
